// File: rtl/y_pkg.sv
// Shared constants for the 2-output stream demultiplexer and its per-output FIFOs.
package y_pkg;
  localparam int SIZE_DEF = 2;
  localparam int DEPTH    = 2;
  localparam int CNT_W    = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
endpackage

// File: rtl/y_fifo2.sv
// Two-entry synchronous FIFO: toggle pointers plus an explicit occupancy count.
module y_fifo2
  import y_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [SIZE-1:0] i_din,
  output logic [SIZE-1:0] o_dout,
  output logic            o_valid,
  output cnt_t            o_count
);

  logic [SIZE-1:0] r_mem [DEPTH];
  logic            r_wptr;
  logic            r_rptr;
  cnt_t            r_cnt;
  logic            w_push;
  logic            w_pop;

  // Requests are gated locally so a full push or empty pop can never corrupt state.
  assign w_push = i_push && (r_cnt != CNT_FULL);
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_valid = (r_cnt != '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/y_demux2_stream.sv
// Steers each accepted input word into FIFO 0 or FIFO 1 according to select bit c.
module y_demux2_stream
  import y_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] a,
  input  logic            c,
  input  logic            a_valid,
  output logic            a_ready,
  output logic [SIZE-1:0] z0,
  output logic            z0_valid,
  input  logic            z0_ready,
  output logic [SIZE-1:0] z1,
  output logic            z1_valid,
  input  logic            z1_ready,
  output cnt_t            cnt0,
  output cnt_t            cnt1
);

  logic w_fire;
  logic w_push0;
  logic w_push1;

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready
  // depends only on registered counts and c, so there is no ready->ready path.
  assign a_ready = c ? (cnt1 != CNT_FULL) : (cnt0 != CNT_FULL);
  assign w_fire  = a_valid && a_ready;
  assign w_push0 = w_fire && !c;
  assign w_push1 = w_fire && c;

  y_fifo2 #(.SIZE(SIZE)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push0),
    .i_pop   (z0_ready),
    .i_din   (a),
    .o_dout  (z0),
    .o_valid (z0_valid),
    .o_count (cnt0)
  );

  y_fifo2 #(.SIZE(SIZE)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_pop   (z1_ready),
    .i_din   (a),
    .o_dout  (z1),
    .o_valid (z1_valid),
    .o_count (cnt1)
  );

endmodule
